vx_alu_pe_sched: RTL and testbench

VX_ALU_PE_SCHED -- requirements
Module: VX_alu_pe_sched

---
 rtl/vx_alu_pe_sched_if.sv | 33 +++
 rtl/vx_alu_pe_sched.sv | 131 +++++++++++++
 tb/tb_vx_alu_pe_sched.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vx_alu_pe_sched_if.sv
// Handshake bundle between the issue front end, the PE array and the merged-result consumer.
// slave is the scheduler side; master is the side driving requests and PE responses.
interface vx_alu_pe_sched_if #(
    parameter int PE_COUNT = 3,
    parameter int DATAW    = 64
);
    localparam int SELW = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;

    logic                      req_valid;
    logic [SELW-1:0]           req_pe_sel;
    logic                      req_ready;
    logic [PE_COUNT-1:0]       pe_req_valid;
    logic [PE_COUNT-1:0]       pe_req_ready;
    logic [PE_COUNT-1:0]       pe_rsp_valid;
    logic [PE_COUNT*DATAW-1:0] pe_rsp_data;
    logic [PE_COUNT-1:0]       pe_rsp_ready;
    logic                      rsp_valid;
    logic [DATAW-1:0]          rsp_data;
    logic [SELW-1:0]           rsp_pe;
    logic                      rsp_ready;
    logic                      busy;
    logic                      err;

    modport slave (
        input  req_valid, req_pe_sel, pe_req_ready, pe_rsp_valid, pe_rsp_data, rsp_ready,
        output req_ready, pe_req_valid, pe_rsp_ready, rsp_valid, rsp_data, rsp_pe, busy, err
    );

    modport master (
        output req_valid, req_pe_sel, pe_req_ready, pe_rsp_valid, pe_rsp_data, rsp_ready,
        input  req_ready, pe_req_valid, pe_rsp_ready, rsp_valid, rsp_data, rsp_pe, busy, err
    );
endinterface

// File: rtl/vx_alu_pe_sched.sv
// Shared-ALU PE scheduler: steers issue requests to one PE under a per-PE in-flight cap
// and merges PE results round-robin into a single registered output slot.
module vx_alu_pe_sched #(
    parameter int PE_COUNT     = 3,
    parameter int DATAW        = 64,
    parameter int MAX_INFLIGHT = 4
) (
    input logic              clk,
    input logic              reset,
    vx_alu_pe_sched_if.slave bus
);
    localparam int SELW = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;
    localparam int CNTW = $clog2(MAX_INFLIGHT + 1);

    logic [CNTW-1:0]     cnt [PE_COUNT];
    logic [SELW-1:0]     ptr;
    logic                rsp_valid_q;
    logic [DATAW-1:0]    rsp_data_q;
    logic [SELW-1:0]     rsp_pe_q;
    logic                err_q;

    logic                sel_ok;
    logic                sel_room;
    logic                sel_pe_ready;
    logic [PE_COUNT-1:0] issue_valid;
    logic [PE_COUNT-1:0] grant_ready;
    logic [PE_COUNT-1:0] cnt_nz;
    logic [PE_COUNT-1:0] issue_fire;
    logic [PE_COUNT-1:0] drain_fire;
    logic [SELW-1:0]     grant;
    logic                grant_any;
    logic [DATAW-1:0]    grant_data;
    logic [SELW:0]       scan_idx;
    logic                rsp_fire;
    logic                underflow;

    // Out-of-range selects match no PE, so they can never be accepted.
    always_comb begin
        sel_ok       = 1'b0;
        sel_room     = 1'b0;
        sel_pe_ready = 1'b0;
        for (int s = 0; s < PE_COUNT; s++) begin
            if (bus.req_pe_sel == SELW'(s)) begin
                sel_ok       = 1'b1;
                sel_room     = cnt[s] < CNTW'(MAX_INFLIGHT);
                sel_pe_ready = bus.pe_req_ready[s];
            end
        end
    end

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        scan_idx  = '0;
        for (int k = PE_COUNT - 1; k >= 0; k--) begin
            scan_idx = {1'b0, ptr} + (SELW + 1)'(k);
            if (scan_idx >= (SELW + 1)'(PE_COUNT)) begin
                scan_idx = scan_idx - (SELW + 1)'(PE_COUNT);
            end
            if (bus.pe_rsp_valid[scan_idx[SELW-1:0]]) begin
                grant     = scan_idx[SELW-1:0];
                grant_any = 1'b1;
            end
        end
    end

    assign rsp_fire = !reset && grant_any && (!rsp_valid_q || bus.rsp_ready);

    always_comb begin
        issue_valid = '0;
        grant_ready = '0;
        cnt_nz      = '0;
        grant_data  = '0;
        for (int s = 0; s < PE_COUNT; s++) begin
            issue_valid[s] = !reset && bus.req_valid && (bus.req_pe_sel == SELW'(s))
                             && (cnt[s] < CNTW'(MAX_INFLIGHT));
            grant_ready[s] = rsp_fire && (grant == SELW'(s));
            cnt_nz[s]      = cnt[s] != '0;
            if (grant == SELW'(s)) begin
                grant_data = bus.pe_rsp_data[s*DATAW +: DATAW];
            end
        end
    end

    assign issue_fire = issue_valid & bus.pe_req_ready;
    assign drain_fire = grant_ready & bus.pe_rsp_valid;
    assign underflow  = |(drain_fire & ~cnt_nz);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < PE_COUNT; s++) begin
                cnt[s] <= '0;
            end
            ptr         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_pe_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            // A response against an empty counter is still forwarded; the count saturates at 0.
            for (int s = 0; s < PE_COUNT; s++) begin
                if (issue_fire[s] && !drain_fire[s]) begin
                    cnt[s] <= cnt[s] + CNTW'(1);
                end else if (!issue_fire[s] && drain_fire[s] && cnt_nz[s]) begin
                    cnt[s] <= cnt[s] - CNTW'(1);
                end
            end
            if ((bus.req_valid && !sel_ok) || underflow) begin
                err_q <= 1'b1;
            end
            if (rsp_fire) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= grant_data;
                rsp_pe_q    <= grant;
                ptr         <= (grant == SELW'(PE_COUNT - 1)) ? '0 : grant + SELW'(1);
            end else if (bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready    = !reset && sel_ok && sel_room && sel_pe_ready;
    assign bus.pe_req_valid = issue_valid;
    assign bus.pe_rsp_ready = grant_ready;
    assign bus.rsp_valid    = rsp_valid_q && !reset;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_pe       = rsp_pe_q;
    assign bus.busy         = rsp_valid_q || (|cnt_nz);
    assign bus.err          = err_q;
endmodule

// File: tb/tb_vx_alu_pe_sched.sv
// Bench for vx_alu_pe_sched: directed scenarios plus random traffic, all outputs
// compared every cycle against a behavioural model of the scheduler rules.
module tb_vx_alu_pe_sched;
    localparam int PEC = 3;
    localparam int DW  = 8;
    localparam int MI  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vx_alu_pe_sched_if #(.PE_COUNT(PEC), .DATAW(DW)) bus ();

    vx_alu_pe_sched #(.PE_COUNT(PEC), .DATAW(DW), .MAX_INFLIGHT(MI)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] pdata [PEC];
    assign bus.pe_rsp_data = {pdata[2], pdata[1], pdata[0]};

    int n_chk  = 0;
    int n_pass = 0;

    int            m_cnt [PEC];
    int            m_ptr;
    bit            m_rv;
    logic [DW-1:0] m_rd;
    int            m_rp;
    bit            m_err;

    int rr_seq [4] = '{0, 1, 2, 0};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int s = 0; s < PEC; s++) m_cnt[s] = 0;
        m_ptr = 0;
        m_rv  = 0;
        m_rd  = '0;
        m_rp  = 0;
        m_err = 0;
    endtask

    task automatic idle();
        bus.req_valid    = 1'b0;
        bus.req_pe_sel   = '0;
        bus.pe_req_ready = '0;
        bus.pe_rsp_valid = '0;
        bus.rsp_ready    = 1'b1;
        for (int s = 0; s < PEC; s++) pdata[s] = '0;
    endtask

    // Compare all outputs against the model mid-cycle, then advance the model one edge.
    task automatic cycle();
        logic [1:0]     sel;
        bit             sel_ok;
        bit             fire;
        bit             busy_e;
        bit             inc;
        bit             dec;
        int             g;
        int             idx;
        logic [PEC-1:0] e_prv;
        logic [PEC-1:0] e_prr;
        bit             e_rr;
        @(negedge clk);
        sel    = bus.req_pe_sel;
        sel_ok = int'(sel) < PEC;
        e_prv  = '0;
        e_rr   = 0;
        if (!reset && sel_ok && m_cnt[sel] < MI) begin
            e_rr = bus.pe_req_ready[sel];
            if (bus.req_valid) e_prv[sel] = 1'b1;
        end
        g = -1;
        for (int k = 0; k < PEC; k++) begin
            idx = (m_ptr + k) % PEC;
            if (g < 0 && bus.pe_rsp_valid[2'(idx)]) g = idx;
        end
        fire  = !reset && g >= 0 && (!m_rv || bus.rsp_ready);
        e_prr = fire ? PEC'(1 << g) : '0;
        busy_e = m_rv;
        for (int s = 0; s < PEC; s++) if (m_cnt[s] != 0) busy_e = 1;
        chk("pe_req_valid", 64'(bus.pe_req_valid), 64'(e_prv));
        chk("req_ready", 64'(bus.req_ready), 64'(e_rr));
        chk("pe_rsp_ready", 64'(bus.pe_rsp_ready), 64'(e_prr));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_rv && !reset));
        chk("rsp_data", 64'(bus.rsp_data), 64'(m_rd));
        chk("rsp_pe", 64'(bus.rsp_pe), 64'(m_rp));
        chk("busy", 64'(bus.busy), 64'(busy_e));
        chk("err", 64'(bus.err), 64'(m_err));
        if (reset) begin
            model_reset();
        end else begin
            for (int s = 0; s < PEC; s++) begin
                inc = e_prv[s] && bus.pe_req_ready[s];
                dec = fire && g == s;
                if (dec && m_cnt[s] == 0) m_err = 1;
                if (inc && !dec) m_cnt[s]++;
                else if (dec && !inc && m_cnt[s] > 0) m_cnt[s]--;
            end
            if (bus.req_valid && !sel_ok) m_err = 1;
            if (fire) begin
                m_rv  = 1;
                m_rd  = pdata[g];
                m_rp  = g;
                m_ptr = (g + 1) % PEC;
            end else if (bus.rsp_ready) begin
                m_rv = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        @(posedge clk);
        #1;
        model_reset();

        // Reset holds valids/readies low even with every input asserted.
        bus.req_valid    = 1'b1;
        bus.req_pe_sel   = 2'd1;
        bus.pe_req_ready = '1;
        bus.pe_rsp_valid = '1;
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'(0));
        chk("rst_pe_req_valid", 64'(bus.pe_req_valid), 64'(0));
        chk("rst_pe_rsp_ready", 64'(bus.pe_rsp_ready), 64'(0));
        cycle();
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_err", 64'(bus.err), 64'(0));
        reset = 1'b0;
        idle();

        // Throttle: cap of two in flight on PE1.
        bus.req_valid    = 1'b1;
        bus.req_pe_sel   = 2'd1;
        bus.pe_req_ready = 3'b111;
        #1 chk("thr_first", 64'(bus.req_ready), 64'(1));
        cycle();
        cycle();
        #1;
        chk("thr_third_blocked", 64'(bus.req_ready), 64'(0));
        chk("thr_third_no_valid", 64'(bus.pe_req_valid), 64'(0));
        bus.pe_rsp_valid = 3'b010;
        pdata[1]         = 8'h5A;
        #1 chk("thr_rsp_grant", 64'(bus.pe_rsp_ready), 64'(3'b010));
        cycle();
        bus.pe_rsp_valid = '0;
        #1;
        chk("thr_third_fires", 64'(bus.req_ready), 64'(1));
        chk("thr_third_valid", 64'(bus.pe_req_valid), 64'(3'b010));
        chk("thr_rsp_out", 64'(bus.rsp_data), 64'(8'h5A));
        cycle();
        bus.req_valid    = 1'b0;
        bus.pe_rsp_valid = 3'b010;
        cycle();
        cycle();
        bus.pe_rsp_valid = '0;
        cycle();
        chk("thr_drained_busy", 64'(bus.busy), 64'(0));
        chk("thr_no_err", 64'(bus.err), 64'(0));

        // Round-robin across all three PEs.
        do_reset();
        pdata[0]         = 8'hA0;
        pdata[1]         = 8'hB1;
        pdata[2]         = 8'hC2;
        bus.pe_rsp_valid = 3'b111;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("rr_pe", 64'(bus.rsp_pe), 64'(rr_seq[i]));
            chk("rr_data", 64'(bus.rsp_data), 64'(pdata[rr_seq[i]]));
        end

        // Backpressure: held result and pointer stay put.
        cycle();
        chk("bp_load", 64'(bus.rsp_data), 64'(8'hB1));
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1 chk("bp_no_grant", 64'(bus.pe_rsp_ready), 64'(0));
            cycle();
            chk("bp_hold_data", 64'(bus.rsp_data), 64'(8'hB1));
            chk("bp_hold_valid", 64'(bus.rsp_valid), 64'(1));
        end
        bus.rsp_ready = 1'b1;
        cycle();
        chk("bp_ptr_held", 64'(bus.rsp_pe), 64'(2));

        // Errors: bad select, then a response with nothing in flight.
        do_reset();
        bus.req_valid  = 1'b1;
        bus.req_pe_sel = 2'd3;
        #1;
        chk("err_sel_ready", 64'(bus.req_ready), 64'(0));
        chk("err_sel_pre", 64'(bus.err), 64'(0));
        cycle();
        chk("err_sel_flag", 64'(bus.err), 64'(1));
        do_reset();
        bus.pe_rsp_valid = 3'b100;
        pdata[2]         = 8'hC2;
        cycle();
        bus.pe_rsp_valid = '0;
        chk("err_uf_valid", 64'(bus.rsp_valid), 64'(1));
        chk("err_uf_pe", 64'(bus.rsp_pe), 64'(2));
        chk("err_uf_data", 64'(bus.rsp_data), 64'(8'hC2));
        chk("err_uf_flag", 64'(bus.err), 64'(1));
        cycle();
        chk("err_uf_cnt0", 64'(bus.busy), 64'(0));

        // Simultaneous issue and response on PE0 with one in flight.
        do_reset();
        bus.req_valid    = 1'b1;
        bus.req_pe_sel   = 2'd0;
        bus.pe_req_ready = 3'b001;
        cycle();
        bus.pe_rsp_valid = 3'b001;
        pdata[0]         = 8'h77;
        cycle();
        chk("sim_busy", 64'(bus.busy), 64'(1));
        idle();
        cycle();
        chk("sim_cnt_kept", 64'(bus.busy), 64'(1));
        bus.pe_rsp_valid = 3'b001;
        cycle();
        idle();
        cycle();
        chk("sim_drained", 64'(bus.busy), 64'(0));

        // Reset in the middle of traffic.
        do_reset();
        bus.req_valid    = 1'b1;
        bus.req_pe_sel   = 2'd0;
        bus.pe_req_ready = 3'b111;
        cycle();
        cycle();
        bus.req_pe_sel = 2'd1;
        cycle();
        cycle();
        bus.req_valid    = 1'b0;
        bus.rsp_ready    = 1'b0;
        bus.pe_rsp_valid = 3'b010;
        cycle();
        bus.pe_rsp_valid = '0;
        bus.req_valid    = 1'b1;
        bus.req_pe_sel   = 2'd3;
        cycle();
        bus.req_valid = 1'b0;
        chk("mid_rsp_valid", 64'(bus.rsp_valid), 64'(1));
        chk("mid_busy", 64'(bus.busy), 64'(1));
        chk("mid_err", 64'(bus.err), 64'(1));
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        idle();
        bus.req_valid    = 1'b1;
        bus.req_pe_sel   = 2'd0;
        bus.pe_req_ready = 3'b001;
        #1;
        chk("mid_rst_valid", 64'(bus.rsp_valid), 64'(0));
        chk("mid_rst_busy", 64'(bus.busy), 64'(0));
        chk("mid_rst_err", 64'(bus.err), 64'(0));
        chk("mid_rst_room", 64'(bus.req_ready), 64'(1));
        cycle();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset            = ($urandom_range(99) < 2);
            bus.req_valid    = 1'($urandom_range(1));
            bus.req_pe_sel   = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
            bus.pe_req_ready = 3'($urandom);
            bus.pe_rsp_valid = 3'($urandom) & 3'($urandom);
            bus.rsp_ready    = ($urandom_range(3) != 0);
            for (int s = 0; s < PEC; s++) pdata[s] = 8'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
